// File: rtl/mem_seq_pkg.sv
// Shared types and the pattern generator for the memory self-test sequencer.
package mem_seq_pkg;

  // Widest data/address the pattern helper supports; callers zero-extend and truncate.
  localparam int unsigned MaxWidth = 256;

  typedef logic [MaxWidth-1:0] wide_t;

  typedef enum logic [1:0] {
    ModeCnt,
    ModeInv,
    ModeAddr,
    ModeSeed
  } mode_e;

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StRead,
    StDrain,
    StDone
  } state_e;

  function automatic wide_t pattern(mode_e mode, wide_t seed, wide_t idx, wide_t addr);
    wide_t p;
    case (mode)
      ModeCnt:  p = idx;
      ModeInv:  p = ~idx;
      ModeAddr: p = addr;
      ModeSeed: p = seed ^ idx;
      default:  p = idx;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/mem_seq_if.sv
// Single-port req/we SRAM bus between the sequencer (master) and the memory (slave).
interface mem_seq_if #(
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned DataWidth = 64
);
  logic                 req;
  logic                 we;
  logic [AddrWidth-1:0] addr;
  logic [DataWidth-1:0] wdata;
  logic [DataWidth-1:0] rdata;

  modport master (output req, output we, output addr, output wdata, input rdata);
  modport slave  (input req, input we, input addr, input wdata, output rdata);
endinterface

// File: rtl/mem_seq_rd_tracker.sv
// Delay line carrying {valid, expected, addr} of each read until its data returns.
module mem_seq_rd_tracker #(
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned Latency   = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 push_i,
  input  logic [DataWidth-1:0] exp_i,
  input  logic [AddrWidth-1:0] addr_i,
  output logic                 cmp_valid_o,
  output logic [DataWidth-1:0] cmp_exp_o,
  output logic [AddrWidth-1:0] cmp_addr_o
);

  logic [Latency-1:0]   vld_q, vld_d;
  logic [DataWidth-1:0] exp_q  [Latency];
  logic [DataWidth-1:0] exp_d  [Latency];
  logic [AddrWidth-1:0] addr_q [Latency];
  logic [AddrWidth-1:0] addr_d [Latency];

  always_comb begin
    vld_d     = vld_q;
    exp_d     = exp_q;
    addr_d    = addr_q;
    vld_d[0]  = push_i;
    exp_d[0]  = exp_i;
    addr_d[0] = addr_i;
    for (int unsigned k = 1; k < Latency; k++) begin
      vld_d[k]  = vld_q[k-1];
      exp_d[k]  = exp_q[k-1];
      addr_d[k] = addr_q[k-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      vld_q <= '0;
      for (int unsigned k = 0; k < Latency; k++) begin
        exp_q[k]  <= '0;
        addr_q[k] <= '0;
      end
    end else begin
      vld_q  <= vld_d;
      exp_q  <= exp_d;
      addr_q <= addr_d;
    end
  end

  assign cmp_valid_o = vld_q[Latency-1];
  assign cmp_exp_o   = exp_q[Latency-1];
  assign cmp_addr_o  = addr_q[Latency-1];

endmodule

// File: rtl/mem_seq_checker.sv
// Memory self-test: writes NumWords patterned words, reads them back and reports mismatches,
// the first failing address and the run length in cycles.
module mem_seq_checker
  import mem_seq_pkg::*;
#(
  parameter int unsigned          AddrWidth   = 64,
  parameter int unsigned          DataWidth   = 64,
  parameter int unsigned          NumWords    = 16,
  parameter logic [AddrWidth-1:0] BaseAddr    = '0,
  parameter int unsigned          ReadLatency = 1,
  parameter int unsigned          CntWidth    = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [1:0]           mode_i,
  input  logic [DataWidth-1:0] seed_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 pass_o,
  output logic [CntWidth-1:0]  err_cnt_o,
  output logic [AddrWidth-1:0] first_err_addr_o,
  output logic [CntWidth-1:0]  cycles_o,
  mem_seq_if.master            mem_io
);

  localparam logic [AddrWidth-1:0] Stride = AddrWidth'(DataWidth / 8);
  localparam int unsigned CntMax = (NumWords > ReadLatency) ? NumWords : ReadLatency;
  localparam int unsigned IdxW   = (CntMax > 1) ? $clog2(CntMax) : 1;
  localparam logic [IdxW-1:0] LastWord  = IdxW'(NumWords - 1);
  localparam logic [IdxW-1:0] LastDrain = IdxW'(ReadLatency - 1);

  state_e               state_q, state_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  mode_e                mode_q, mode_d;
  logic [DataWidth-1:0] seed_q, seed_d;
  logic [CntWidth-1:0]  err_cnt_q, err_cnt_d;
  logic [AddrWidth-1:0] first_err_q, first_err_d;
  logic [CntWidth-1:0]  cycles_q, cycles_d;
  logic                 pass_q, pass_d;

  logic                 run_w, mismatch_w;
  wide_t                pat_w;
  logic [DataWidth-1:0] exp_w;
  logic                 cmp_valid;
  logic [DataWidth-1:0] cmp_exp;
  logic [AddrWidth-1:0] cmp_addr;
  logic                 unused_pat;

  assign pat_w      = pattern(mode_q, wide_t'(seed_q), wide_t'(idx_q), wide_t'(addr_q));
  assign exp_w      = pat_w[DataWidth-1:0];
  assign unused_pat = ^pat_w[MaxWidth-1:DataWidth];
  assign run_w      = state_q inside {StWrite, StRead, StDrain};
  assign mismatch_w = cmp_valid && (mem_io.rdata != cmp_exp);

  mem_seq_rd_tracker #(
    .AddrWidth (AddrWidth),
    .DataWidth (DataWidth),
    .Latency   (ReadLatency)
  ) u_rd_tracker (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (state_q == StRead),
    .exp_i       (exp_w),
    .addr_i      (addr_q),
    .cmp_valid_o (cmp_valid),
    .cmp_exp_o   (cmp_exp),
    .cmp_addr_o  (cmp_addr)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= StIdle;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start_i) state_d = StWrite;
      StWrite: if (idx_q == LastWord) state_d = StRead;
      StRead:  if (idx_q == LastWord) state_d = StDrain;
      StDrain: if (idx_q == LastDrain) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    idx_d       = idx_q;
    addr_d      = addr_q;
    mode_d      = mode_q;
    seed_d      = seed_q;
    err_cnt_d   = err_cnt_q;
    first_err_d = first_err_q;
    cycles_d    = cycles_q;
    pass_d      = pass_q;
    if (state_q == StIdle) begin
      if (start_i) begin
        mode_d      = mode_e'(mode_i);
        seed_d      = seed_i;
        err_cnt_d   = '0;
        first_err_d = '0;
        cycles_d    = '0;
        pass_d      = 1'b0;
        idx_d       = '0;
        addr_d      = BaseAddr;
      end
    end else begin
      if (run_w && cycles_q != '1) cycles_d = cycles_q + 1'b1;
      if (mismatch_w) begin
        if (err_cnt_q == '0) first_err_d = cmp_addr;
        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
      end
      if (state_q inside {StWrite, StRead}) begin
        if (idx_q == LastWord) begin
          idx_d  = '0;
          addr_d = BaseAddr;
        end else begin
          idx_d  = idx_q + 1'b1;
          addr_d = addr_q + Stride;
        end
      end
      if (state_q == StDrain) begin
        idx_d = idx_q + 1'b1;
        // The last compare lands in the final drain cycle, so judge on the updated count.
        if (idx_q == LastDrain) pass_d = (err_cnt_d == '0);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      idx_q       <= '0;
      addr_q      <= '0;
      mode_q      <= ModeCnt;
      seed_q      <= '0;
      err_cnt_q   <= '0;
      first_err_q <= '0;
      cycles_q    <= '0;
      pass_q      <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      addr_q      <= addr_d;
      mode_q      <= mode_d;
      seed_q      <= seed_d;
      err_cnt_q   <= err_cnt_d;
      first_err_q <= first_err_d;
      cycles_q    <= cycles_d;
      pass_q      <= pass_d;
    end
  end

  always_comb begin
    busy_o       = run_w;
    done_o       = 1'b0;
    mem_io.req   = 1'b0;
    mem_io.we    = 1'b0;
    mem_io.addr  = '0;
    mem_io.wdata = '0;
    case (state_q)
      StWrite: begin
        mem_io.req   = 1'b1;
        mem_io.we    = 1'b1;
        mem_io.addr  = addr_q;
        mem_io.wdata = exp_w;
      end
      StRead: begin
        mem_io.req  = 1'b1;
        mem_io.addr = addr_q;
      end
      StDone:  done_o = 1'b1;
      default: ;
    endcase
  end

  assign pass_o           = pass_q;
  assign err_cnt_o        = err_cnt_q;
  assign first_err_addr_o = first_err_q;
  assign cycles_o         = cycles_q;

endmodule

// File: tb/tb_mem_seq_checker.sv
// Bench for mem_seq_checker: two instances (latency 1 at base 0, latency 3 at a wrapping base)
// share stimulus; each has a small word memory with per-word read corruption.
module tb_mem_seq_checker;

  localparam int          NW     = 4;
  localparam logic [63:0] BASE_A = 64'h0;
  localparam logic [63:0] BASE_B = 64'hFFFF_FFFF_FFFF_FFF0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  mode;
  logic [63:0] seed;
  logic [3:0]  corrupt;

  always #5 clk = ~clk;

  mem_seq_if #(.AddrWidth(64), .DataWidth(64)) a_if ();
  mem_seq_if #(.AddrWidth(64), .DataWidth(64)) b_if ();

  logic        busy_a, done_a, pass_a, busy_b, done_b, pass_b;
  logic [15:0] err_a, cyc_a, err_b, cyc_b;
  logic [63:0] first_a, first_b;

  mem_seq_checker #(.AddrWidth(64), .DataWidth(64), .NumWords(NW), .BaseAddr(BASE_A),
                    .ReadLatency(1), .CntWidth(16)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .mode_i(mode), .seed_i(seed),
    .busy_o(busy_a), .done_o(done_a), .pass_o(pass_a), .err_cnt_o(err_a),
    .first_err_addr_o(first_a), .cycles_o(cyc_a), .mem_io(a_if)
  );

  mem_seq_checker #(.AddrWidth(64), .DataWidth(64), .NumWords(NW), .BaseAddr(BASE_B),
                    .ReadLatency(3), .CntWidth(16)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .mode_i(mode), .seed_i(seed),
    .busy_o(busy_b), .done_o(done_b), .pass_o(pass_b), .err_cnt_o(err_b),
    .first_err_addr_o(first_b), .cycles_o(cyc_b), .mem_io(b_if)
  );

  // Word memories indexed by word number relative to each base.
  logic [63:0] mem_a [16];
  logic [63:0] mem_b [16];
  logic [3:0]  a_idx, b_idx;
  logic [63:0] pipe_a;
  logic [63:0] pipe_b [3];

  assign a_idx      = 4'((a_if.addr - BASE_A) >> 3);
  assign b_idx      = 4'((b_if.addr - BASE_B) >> 3);
  assign a_if.rdata = pipe_a;
  assign b_if.rdata = pipe_b[2];

  always @(posedge clk) begin
    if (a_if.req && a_if.we) mem_a[a_idx] <= a_if.wdata;
    pipe_a <= corrupt[a_idx[1:0]] ? 64'hDEAD : mem_a[a_idx];
    if (b_if.req && b_if.we) mem_b[b_idx] <= b_if.wdata;
    pipe_b[0] <= corrupt[b_idx[1:0]] ? 64'hDEAD : mem_b[b_idx];
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end

  int total = 0;
  int bad   = 0;

  logic [63:0] wa_a[$], wd_a[$], wa_b[$], wd_b[$];
  int          done_at_a, done_at_b, dcnt_a, dcnt_b;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model_pat(logic [1:0] m, logic [63:0] s, int i,
                                            logic [63:0] base);
    logic [63:0] iv = 64'(i);
    case (m)
      2'd0:    return iv;
      2'd1:    return ~iv;
      2'd2:    return base + iv * 64'd8;
      default: return s ^ iv;
    endcase
  endfunction

  task automatic model_errs(input logic [1:0] m, input logic [63:0] s, input logic [3:0] cm,
                            input logic [63:0] base, output int errs, output logic [63:0] first);
    errs  = 0;
    first = 64'h0;
    for (int i = 0; i < NW; i++) begin
      if (cm[i] && model_pat(m, s, i, base) != 64'hDEAD) begin
        if (errs == 0) first = base + 64'(i) * 64'd8;
        errs++;
      end
    end
  endtask

  task automatic run(input logic [1:0] m, input logic [63:0] s, input logic [3:0] cm,
                     input int restart_at);
    wa_a.delete(); wd_a.delete(); wa_b.delete(); wd_b.delete();
    done_at_a = -1; done_at_b = -1; dcnt_a = 0; dcnt_b = 0;
    @(negedge clk);
    start = 1'b1; mode = m; seed = s; corrupt = cm;
    for (int k = 1; k < 40; k++) begin
      @(negedge clk);
      start = (k == restart_at);
      if (a_if.req && a_if.we) begin wa_a.push_back(a_if.addr); wd_a.push_back(a_if.wdata); end
      if (b_if.req && b_if.we) begin wa_b.push_back(b_if.addr); wd_b.push_back(b_if.wdata); end
      if (done_a) begin dcnt_a++; if (done_at_a < 0) done_at_a = k; end
      if (done_b) begin dcnt_b++; if (done_at_b < 0) done_at_b = k; end
    end
    start = 1'b0;
  endtask

  task automatic check_run(input bit sel, input string tag, input logic [1:0] m,
                           input logic [63:0] s, input logic [3:0] cm);
    logic [63:0] base, xfirst, err, first, cyc;
    logic [63:0] aq[$], dq[$];
    int          lat, xerr, dat, dc;
    logic        busy, pass;
    string       n;
    if (!sel) begin
      base = BASE_A; lat = 1; aq = wa_a; dq = wd_a; dat = done_at_a; dc = dcnt_a;
      busy = busy_a; pass = pass_a; err = 64'(err_a); first = first_a; cyc = 64'(cyc_a);
    end else begin
      base = BASE_B; lat = 3; aq = wa_b; dq = wd_b; dat = done_at_b; dc = dcnt_b;
      busy = busy_b; pass = pass_b; err = 64'(err_b); first = first_b; cyc = 64'(cyc_b);
    end
    n = $sformatf("%s.%s", tag, sel ? "B" : "A");
    model_errs(m, s, cm, base, xerr, xfirst);
    check({n, ".done_at"}, 64'(dat), 64'(2 * NW + lat + 1));
    check({n, ".done_cnt"}, 64'(dc), 64'd1);
    check({n, ".busy"}, 64'(busy), 64'd0);
    check({n, ".err_cnt"}, err, 64'(xerr));
    check({n, ".first_err"}, first, xfirst);
    check({n, ".pass"}, 64'(pass), 64'(xerr == 0));
    check({n, ".cycles"}, cyc, 64'(2 * NW + lat));
    check({n, ".n_writes"}, 64'(aq.size()), 64'(NW));
    for (int i = 0; i < NW; i++) begin
      if (i < aq.size()) begin
        check($sformatf("%s.waddr%0d", n, i), aq[i], base + 64'(i) * 64'd8);
        check($sformatf("%s.wdata%0d", n, i), dq[i], model_pat(m, s, i, base));
      end
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".A.busy"}, 64'(busy_a), 64'd0);
    check({tag, ".A.done"}, 64'(done_a), 64'd0);
    check({tag, ".A.pass"}, 64'(pass_a), 64'd0);
    check({tag, ".A.err"}, 64'(err_a), 64'd0);
    check({tag, ".A.first"}, first_a, 64'd0);
    check({tag, ".A.cycles"}, 64'(cyc_a), 64'd0);
    check({tag, ".A.req"}, 64'({a_if.req, a_if.we}), 64'd0);
    check({tag, ".A.addr"}, a_if.addr, 64'd0);
    check({tag, ".A.wdata"}, a_if.wdata, 64'd0);
    check({tag, ".B.busy"}, 64'(busy_b), 64'd0);
    check({tag, ".B.req"}, 64'({b_if.req, b_if.we}), 64'd0);
    check({tag, ".B.addr"}, b_if.addr, 64'd0);
    check({tag, ".B.cycles"}, 64'(cyc_b), 64'd0);
  endtask

  typedef struct {
    logic [1:0]  mode;
    logic [63:0] seed;
    logic [3:0]  corrupt;
    int          restart;
    int          err;
    logic [63:0] first;
    logic        pass;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int nd;
    vecs[0] = '{2'd0, 64'h0, 4'b0000, -1, 0, 64'd0, 1'b1};
    vecs[1] = '{2'd3, 64'h0123_4567_89AB_CDEF, 4'b0000, -1, 0, 64'd0, 1'b1};
    vecs[2] = '{2'd0, 64'h0, 4'b0100, -1, 1, 64'd16, 1'b0};
    vecs[3] = '{2'd1, 64'h0, 4'b1010, -1, 2, 64'd8, 1'b0};
    vecs[4] = '{2'd2, 64'h0, 4'b0000, 3, 0, 64'd0, 1'b1};

    rst_n = 1'b0; start = 1'b0; mode = 2'd0; seed = 64'h0; corrupt = 4'h0;
    repeat (3) @(negedge clk);
    check_idle("rst");
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("post_rst");

    for (int r = 0; r < 5; r++) begin
      run(vecs[r].mode, vecs[r].seed, vecs[r].corrupt, vecs[r].restart);
      check($sformatf("vec%0d.A.tbl_err", r), 64'(err_a), 64'(vecs[r].err));
      check($sformatf("vec%0d.A.tbl_first", r), first_a, vecs[r].first);
      check($sformatf("vec%0d.A.tbl_pass", r), 64'(pass_a), 64'(vecs[r].pass));
      check($sformatf("vec%0d.A.tbl_done", r), 64'(done_at_a), 64'd10);
      check($sformatf("vec%0d.B.tbl_done", r), 64'(done_at_b), 64'd12);
      if (r == 0 && wa_b.size() == NW) begin
        check("wrap.B.addr0", wa_b[0], 64'hFFFF_FFFF_FFFF_FFF0);
        check("wrap.B.addr2", wa_b[2], 64'h0);
        check("wrap.B.addr3", wa_b[3], 64'h8);
      end
      if (r == 1 && wd_a.size() == NW) check("seed.A.wdata2", wd_a[2], 64'h0123_4567_89AB_CDED);
      check_run(1'b0, $sformatf("vec%0d", r), vecs[r].mode, vecs[r].seed, vecs[r].corrupt);
      check_run(1'b1, $sformatf("vec%0d", r), vecs[r].mode, vecs[r].seed, vecs[r].corrupt);
    end

    // Reset sampled at the end of cycle 2 (mid write) aborts both instances.
    @(negedge clk);
    start = 1'b1; mode = 2'd3; seed = 64'hA5A5; corrupt = 4'h0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_idle("midrst");
    nd = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done_a || done_b || busy_a || busy_b) nd++;
    end
    check("midrst.no_activity", 64'(nd), 64'd0);
    run(2'd0, 64'h0, 4'h0, -1);
    check_run(1'b0, "after_rst", 2'd0, 64'h0, 4'h0);
    check_run(1'b1, "after_rst", 2'd0, 64'h0, 4'h0);

    for (int r = 0; r < 8; r++) begin
      logic [1:0]  m;
      logic [63:0] s;
      logic [3:0]  cm;
      m  = 2'($urandom_range(0, 3));
      s  = {$urandom, $urandom};
      cm = 4'($urandom_range(0, 15));
      run(m, s, cm, int'($urandom_range(2, 9)));
      check_run(1'b0, $sformatf("rnd%0d", r), m, s, cm);
      check_run(1'b1, $sformatf("rnd%0d", r), m, s, cm);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
